// File: rtl/byte_pair_sorter.sv
// -----------------------------------------------------------------------------
// byte_pair_sorter
//
// Registered two-element compare-and-swap node. It is the leaf sorting stage
// of the mergesort datapath. Two words enter every cycle. One cycle later they
// leave in sorted order. `left` is the element that the parent treats as the
// more significant one when it concatenates the merged list.
//
// Parameters
//   WIDTH      : bit width of each data word
//   DESCENDING : 0 = ascending (left = min), 1 = descending (left = max)
//   SIGNED_CMP : 0 = unsigned magnitude compare, 1 = two's-complement compare
//
// Ports
//   clock   in   system clock, rising-edge active
//   reset   in   asynchronous active-low reset (0 = in reset)
//   word1   in   first unsorted operand
//   word2   in   second unsorted operand
//   left    out  registered first sorted element
//   right   out  registered second sorted element
//   swapped out  registered flag, 1 when the operands were exchanged
//   valid   out  registered flag, 1 once outputs hold a post-reset result
// -----------------------------------------------------------------------------
module byte_pair_sorter #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DESCENDING = 1'b0,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             swapped,
  output logic             valid
);

  logic             gt_12;    // word1 > word2
  logic             gt_21;    // word2 > word1
  logic             swap;

  logic [WIDTH-1:0] left_d,    left_q;
  logic [WIDTH-1:0] right_d,   right_q;
  logic             swapped_d, swapped_q;
  logic             valid_d,   valid_q;

  // Both strict comparisons are formed. Equal operands never swap in either
  // order, so the ordering stays stable.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    gt_12 = 1'b0;
    gt_21 = 1'b0;
    if (SIGNED_CMP) begin
      gt_12 = $signed(word1) > $signed(word2);
      gt_21 = $signed(word2) > $signed(word1);
    end else begin
      gt_12 = word1 > word2;
      gt_21 = word2 > word1;
    end
    swap = DESCENDING ? gt_21 : gt_12;
  end

  always_comb begin
    left_d    = swap ? word2 : word1;
    right_d   = swap ? word1 : word2;
    swapped_d = swap;
    valid_d   = 1'b1;
  end

  // Reset is in the sensitivity list, so asserting it clears the stage at
  // once. An in-flight pair is dropped without waiting for an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      left_q    <= '0;
      right_q   <= '0;
      swapped_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      left_q    <= left_d;
      right_q   <= right_d;
      swapped_q <= swapped_d;
      valid_q   <= valid_d;
    end
  end

  assign left    = left_q;
  assign right   = right_q;
  assign swapped = swapped_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_byte_pair_sorter.sv
// -----------------------------------------------------------------------------
// tb_byte_pair_sorter
//
// Drives three byte_pair_sorter variants with the same input stream: ascending
// unsigned, descending unsigned, and ascending signed. The stimulus process
// pushes the expected sorted pair for every sampled edge into a scoreboard
// queue. A monitor on the falling edge pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_byte_pair_sorter;

  localparam int W  = 8;
  localparam int NV = 3;  // variants: 0 asc/unsigned, 1 desc/unsigned, 2 asc/signed

  typedef struct packed {
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         swapped;
  } res_t;

  typedef struct {
    res_t r [NV];
  } exp_t;

  logic         clock;
  logic         reset;
  logic [W-1:0] word1;
  logic [W-1:0] word2;
  logic [W-1:0] left_o    [NV];
  logic [W-1:0] right_o   [NV];
  logic         swapped_o [NV];
  logic         valid_o   [NV];

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  byte_pair_sorter #(.WIDTH(W), .DESCENDING(1'b0), .SIGNED_CMP(1'b0)) u_asc (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2),
    .left(left_o[0]), .right(right_o[0]), .swapped(swapped_o[0]), .valid(valid_o[0]));

  byte_pair_sorter #(.WIDTH(W), .DESCENDING(1'b1), .SIGNED_CMP(1'b0)) u_desc (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2),
    .left(left_o[1]), .right(right_o[1]), .swapped(swapped_o[1]), .valid(valid_o[1]));

  byte_pair_sorter #(.WIDTH(W), .DESCENDING(1'b0), .SIGNED_CMP(1'b1)) u_sgn (
    .clock(clock), .reset(reset), .word1(word1), .word2(word2),
    .left(left_o[2]), .right(right_o[2]), .swapped(swapped_o[2]), .valid(valid_o[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret each byte as a number and pick which one goes on the
  // left. Ties keep word1 on the left.
  function automatic res_t ref_sort(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit desc, input bit sgn);
    res_t res;
    int   va = int'(a);
    int   vb = int'(b);
    bit   keep;
    if (sgn && va >= 128) va -= 256;
    if (sgn && vb >= 128) vb -= 256;
    keep        = desc ? (va >= vb) : (va <= vb);
    res.left    = keep ? a : b;
    res.right   = keep ? b : a;
    res.swapped = !keep;
    return res;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.r[0] = ref_sort(a, b, 1'b0, 1'b0);
    e.r[1] = ref_sort(a, b, 1'b1, 1'b0);
    e.r[2] = ref_sort(a, b, 1'b0, 1'b1);
    return e;
  endfunction

  // One input slot: drive just after the falling edge. The following rising
  // edge samples it.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic rst_val);
    @(negedge clock);
    #1;
    reset = rst_val;
    word1 = a;
    word2 = b;
    if (rst_val) sb.push_back(model(a, b));
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("%s_left[%0d]", tag, i),    32'(left_o[i]),    32'h0);
      check($sformatf("%s_right[%0d]", tag, i),   32'(right_o[i]),   32'h0);
      check($sformatf("%s_swapped[%0d]", tag, i), 32'(swapped_o[i]), 32'h0);
      check($sformatf("%s_valid[%0d]", tag, i),   32'(valid_o[i]),   32'h0);
    end
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NV; i++) begin
          check($sformatf("sb_valid[%0d]", i),   32'(valid_o[i]),   32'h1);
          check($sformatf("sb_left[%0d]", i),    32'(left_o[i]),    32'(e.r[i].left));
          check($sformatf("sb_right[%0d]", i),   32'(right_o[i]),   32'(e.r[i].right));
          check($sformatf("sb_swapped[%0d]", i), 32'(swapped_o[i]), 32'(e.r[i].swapped));
        end
      end else if (!reset) begin
        check_cleared("mon_rst");
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    word1 = 8'h12;
    word2 = 8'h34;

    // Held in reset with live inputs and a running clock.
    repeat (3) begin
      @(negedge clock);
      check_cleared("reset_hold");
    end

    // Release between edges and send an ordered pair.
    step(8'h05, 8'hA0, 1'b1);
    @(posedge clock); #1;
    check("dir_pass_left",  32'(left_o[0]),    32'h05);
    check("dir_pass_right", 32'(right_o[0]),   32'hA0);
    check("dir_pass_valid", 32'(valid_o[0]),   32'h1);

    step(8'hC8, 8'h17, 1'b1);
    @(posedge clock); #1;
    check("dir_swap_left",  32'(left_o[0]),    32'h17);
    check("dir_swap_right", 32'(right_o[0]),   32'hC8);
    check("dir_swap_flag",  32'(swapped_o[0]), 32'h1);

    step(8'hFF, 8'h00, 1'b1);
    @(posedge clock); #1;
    check("dir_ext_left",  32'(left_o[0]),  32'h00);
    check("dir_ext_right", 32'(right_o[0]), 32'hFF);

    step(8'h42, 8'h42, 1'b1);
    @(posedge clock); #1;
    check("dir_eq_left",  32'(left_o[0]),    32'h42);
    check("dir_eq_right", 32'(right_o[0]),   32'h42);
    check("dir_eq_flag",  32'(swapped_o[0]), 32'h0);

    // Back-to-back stream, including the signed boundary pair.
    step(8'h09, 8'h03, 1'b1);
    step(8'h01, 8'h02, 1'b1);
    step(8'h80, 8'h7F, 1'b1);
    @(posedge clock); #1;
    check("dir_stream_left",  32'(left_o[0]),  32'h7F);
    check("dir_stream_right", 32'(right_o[0]), 32'h80);

    // Parameter variants.
    step(8'h10, 8'h20, 1'b1);
    @(posedge clock); #1;
    check("dir_desc_left",  32'(left_o[1]),    32'h20);
    check("dir_desc_right", 32'(right_o[1]),   32'h10);
    check("dir_desc_flag",  32'(swapped_o[1]), 32'h1);

    step(8'h7F, 8'h80, 1'b1);
    @(posedge clock); #1;
    check("dir_sgn_left",  32'(left_o[2]),    32'h80);
    check("dir_sgn_right", 32'(right_o[2]),   32'h7F);
    check("dir_sgn_flag",  32'(swapped_o[2]), 32'h1);

    // Asynchronous reset mid-stream: drop it between edges and expect the
    // outputs to clear without a clock edge.
    step(8'hC8, 8'h17, 1'b1);
    @(posedge clock); #1;
    check("dir_pre_rst_left", 32'(left_o[0]), 32'h17);
    #1;
    reset = 1'b0;
    sb.delete();  // the in-flight result is discarded
    #1;
    check_cleared("async_rst");
    step(8'h33, 8'h11, 1'b1);
    @(posedge clock); #1;
    check("dir_rerel_valid", 32'(valid_o[0]), 32'h1);
    check("dir_rerel_left",  32'(left_o[0]),  32'h11);

    // Randomized stream with occasional reset pulses applied between edges.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;           // exercise ties
      if ($urandom_range(0, 39) == 0) step(a, b, 1'b0);
      else                            step(a, b, 1'b1);
    end
    step(8'h00, 8'h00, 1'b1);

    repeat (2) @(negedge clock);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
